sid_bus_multi: RTL and testbench

//  Parametrised multi-SID bus front end; successor to the single-SID register interface.

---
 rtl/sid_bus_multi.sv | 273 +++++++++++++++++++++++++++
 tb/tb_sid_bus_multi.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_bus_multi.sv
`default_nettype none
// ============================================================================
//  Module   : sid_bus_multi
//  Purpose  : Multi-SID bus front end. Turns sampled C64 bus cycles into
//             per-core register writes, returns read data, emulates each
//             chip's decaying data-bus latch and runs the magic-byte unlock
//             sequence that selects each chip's model (6581 / 8580).
//  Ports    : clk, rst_n        clock, asynchronous active-low reset
//             tick              phi2 strobe clocking the decay counters
//             bus_valid, cs,    bus access qualifier, chip selects,
//             addr, data_i, we  register address, write data, direction
//             oe                host read enable (gates data_oe)
//             res               synchronous SID chip reset (bus RES)
//             ro_bytes          per-SID {POTX,POTY,OSC3,ENV3}
//             reg_we/sel/addr/data  registered write towards the cores
//             reg_clr           clear-all pulse on RES rising edge
//             data_o, data_oe   read data and its valid/drive enable
//             model_o           per-SID model (0=MOS6581, 1=MOS8580)
//  Revision : 1.0  initial release
// ============================================================================
module sid_bus_multi #(
   parameter int                 N_SID      = 2,
   parameter int                 DECAY_W    = 24,
   parameter logic [DECAY_W-1:0] DECAY_6581 = DECAY_W'(24'h001d00),
   parameter logic [DECAY_W-1:0] DECAY_8580 = DECAY_W'(24'h0a2000),
   parameter logic [N_SID-1:0]   MODEL_RST  = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic                 bus_valid,
   input  logic [N_SID-1:0]     cs,
   input  logic [4:0]           addr,
   input  logic [7:0]           data_i,
   input  logic                 we,
   input  logic                 oe,
   input  logic                 res,
   input  logic [N_SID*32-1:0]  ro_bytes,
   output logic                 reg_we,
   output logic [N_SID-1:0]     reg_sel,
   output logic [4:0]           reg_addr,
   output logic [7:0]           reg_data,
   output logic                 reg_clr,
   output logic [7:0]           data_o,
   output logic                 data_oe,
   output logic [N_SID-1:0]     model_o
);

   localparam int SID_W = (N_SID > 1) ? $clog2(N_SID) : 1;

   localparam logic [4:0] ADDR_MAGIC = 5'h1F;
   localparam logic [4:0] ADDR_MODEL = 5'h1E;
   localparam logic [4:0] ADDR_RO_LO = 5'h19;
   localparam logic [4:0] ADDR_RO_HI = 5'h1C;
   localparam logic [7:0] MAGIC_0    = 8'h52;
   localparam logic [7:0] MAGIC_1    = 8'h44;
   localparam logic [7:0] MAGIC_2    = 8'h49;
   localparam logic [7:0] MAGIC_3    = 8'h50;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_M1   = 3'd1,
      ST_M2   = 3'd2,
      ST_M3   = 3'd3,
      ST_UNLK = 3'd4
   } state_e;

   // ------------------------------------------------------------------------
   // Access decode
   // ------------------------------------------------------------------------
   logic [SID_W-1:0] sid;
   logic             acc;
   logic             wr;
   logic             rd;
   logic             ro_hit;
   logic [31:0]      ro_arr [N_SID];
   logic [31:0]      ro_word;
   logic [7:0]       ro_byte;

   // Lowest-numbered asserted chip select wins.
   always_comb begin
      sid = '0;
      for (int i = N_SID - 1; i >= 0; i--) begin
         if (cs[i]) sid = SID_W'(i);
      end
   end

   // RES masks every bus access in the cycle it is high.
   assign acc    = bus_valid & (|cs) & ~res;
   assign wr     = acc & we;
   assign rd     = acc & ~we;
   assign ro_hit = (addr >= ADDR_RO_LO) && (addr <= ADDR_RO_HI);

   for (genvar g = 0; g < N_SID; g++) begin : g_ro
      assign ro_arr[g] = ro_bytes[32*g +: 32];
   end

   assign ro_word = ro_arr[sid];

   // POTX sits in the MSB of each 32-bit group, ENV3 in the LSB.
   always_comb begin
      ro_byte = ro_word[7:0];
      case (addr)
         5'h19:   ro_byte = ro_word[31:24];
         5'h1A:   ro_byte = ro_word[23:16];
         5'h1B:   ro_byte = ro_word[15:8];
         default: ro_byte = ro_word[7:0];
      endcase
   end

   // ------------------------------------------------------------------------
   // Magic unlock FSM (one shared instance) and model register
   // ------------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [SID_W-1:0] msid_q, msid_d;
   logic [N_SID-1:0] model_q, model_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         msid_q  <= '0;
         model_q <= MODEL_RST;
      end else begin
         state_q <= state_d;
         msid_q  <= msid_d;
         model_q <= model_d;
      end
   end

   always_comb begin
      state_d = state_q;
      msid_d  = msid_q;
      model_d = model_q;
      if (res) begin
         state_d = ST_IDLE;
      end else if (wr) begin
         // Any write that does not advance the sequence drops back to idle.
         state_d = ST_IDLE;
         case (state_q)
            ST_M1: if (addr == ADDR_MAGIC && data_i == MAGIC_1 && sid == msid_q) state_d = ST_M2;
            ST_M2: if (addr == ADDR_MAGIC && data_i == MAGIC_2 && sid == msid_q) state_d = ST_M3;
            ST_M3: if (addr == ADDR_MAGIC && data_i == MAGIC_3 && sid == msid_q) state_d = ST_UNLK;
            ST_UNLK: begin
               if (addr == ADDR_MODEL && sid == msid_q) model_d[msid_q] = data_i[0];
            end
            default: ;
         endcase
         // The first magic byte always (re)starts the sequence on this chip.
         if (addr == ADDR_MAGIC && data_i == MAGIC_0) begin
            state_d = ST_M1;
            msid_d  = sid;
         end
      end
   end

   assign model_o = model_q;

   // ------------------------------------------------------------------------
   // Per-SID bus latch with decay
   // ------------------------------------------------------------------------
   logic [7:0]         latch_q [N_SID];
   logic [7:0]         latch_d [N_SID];
   logic [DECAY_W-1:0] decay_q [N_SID];
   logic [DECAY_W-1:0] decay_d [N_SID];

   always_comb begin
      logic [DECAY_W-1:0] reload;
      logic               hit;
      reload = DECAY_6581;
      hit    = 1'b0;
      for (int i = 0; i < N_SID; i++) begin
         // model_d so that a model change reloads with the new chip's timing.
         reload     = model_d[i] ? DECAY_8580 : DECAY_6581;
         hit        = (sid == SID_W'(i));
         latch_d[i] = latch_q[i];
         decay_d[i] = decay_q[i];
         if (res) begin
            latch_d[i] = '0;
            decay_d[i] = reload;
         end else if (wr && hit) begin
            latch_d[i] = data_i;
            decay_d[i] = reload;
         end else if (rd && hit && ro_hit) begin
            latch_d[i] = ro_byte;
            decay_d[i] = reload;
         end else if (tick && decay_q[i] != '0) begin
            decay_d[i] = decay_q[i] - DECAY_W'(1);
            if (decay_q[i] == DECAY_W'(1)) latch_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_SID; i++) begin
            latch_q[i] <= '0;
            decay_q[i] <= MODEL_RST[i] ? DECAY_8580 : DECAY_6581;
         end
      end else begin
         latch_q <= latch_d;
         decay_q <= decay_d;
      end
   end

   // ------------------------------------------------------------------------
   // Output registers
   // ------------------------------------------------------------------------
   logic             reg_we_q,   reg_we_d;
   logic [N_SID-1:0] reg_sel_q,  reg_sel_d;
   logic [4:0]       reg_addr_q, reg_addr_d;
   logic [7:0]       reg_data_q, reg_data_d;
   logic             reg_clr_q,  reg_clr_d;
   logic             res_q,      res_d;
   logic [7:0]       data_o_q,   data_o_d;
   logic             data_oe_q,  data_oe_d;

   always_comb begin
      reg_we_d   = wr;
      reg_sel_d  = reg_sel_q;
      reg_addr_d = reg_addr_q;
      reg_data_d = reg_data_q;
      if (wr) begin
         reg_sel_d  = N_SID'(1) << sid;
         reg_addr_d = addr;
         reg_data_d = data_i;
      end

      res_d     = res;
      reg_clr_d = res & ~res_q;

      data_o_d = data_o_q;
      if (rd) data_o_d = ro_hit ? ro_byte : latch_q[sid];

      // A read sets the enable even when oe is low; it then drops a cycle later.
      data_oe_d = data_oe_q;
      if (res)                      data_oe_d = 1'b0;
      else if (rd)                  data_oe_d = 1'b1;
      else if (bus_valid && ~(|cs)) data_oe_d = 1'b0;
      else if (!oe)                 data_oe_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_we_q   <= 1'b0;
         reg_sel_q  <= '0;
         reg_addr_q <= '0;
         reg_data_q <= '0;
         reg_clr_q  <= 1'b0;
         res_q      <= 1'b0;
         data_o_q   <= '0;
         data_oe_q  <= 1'b0;
      end else begin
         reg_we_q   <= reg_we_d;
         reg_sel_q  <= reg_sel_d;
         reg_addr_q <= reg_addr_d;
         reg_data_q <= reg_data_d;
         reg_clr_q  <= reg_clr_d;
         res_q      <= res_d;
         data_o_q   <= data_o_d;
         data_oe_q  <= data_oe_d;
      end
   end

   assign reg_we   = reg_we_q;
   assign reg_sel  = reg_sel_q;
   assign reg_addr = reg_addr_q;
   assign reg_data = reg_data_q;
   assign reg_clr  = reg_clr_q;
   assign data_o   = data_o_q;
   assign data_oe  = data_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_sid_bus_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sid_bus_multi
//  Purpose  : Self-checking bench for sid_bus_multi (N_SID=2, default decay).
//             A behavioural model tracks latch age in ticks and keeps a short
//             write history to recognise the unlock sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sid_bus_multi;

   localparam int L6581 = 'h1d00;
   localparam int L8580 = 'h0a2000;

   logic        clk;
   logic        rst_n;
   logic        tick;
   logic        bus_valid;
   logic [1:0]  cs;
   logic [4:0]  addr;
   logic [7:0]  data_i;
   logic        we;
   logic        oe;
   logic        res;
   logic [63:0] ro_bytes;
   logic        reg_we;
   logic [1:0]  reg_sel;
   logic [4:0]  reg_addr;
   logic [7:0]  reg_data;
   logic        reg_clr;
   logic [7:0]  data_o;
   logic        data_oe;
   logic [1:0]  model_o;

   sid_bus_multi #(.N_SID(2)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .bus_valid(bus_valid),
      .cs(cs), .addr(addr), .data_i(data_i), .we(we), .oe(oe), .res(res),
      .ro_bytes(ro_bytes), .reg_we(reg_we), .reg_sel(reg_sel),
      .reg_addr(reg_addr), .reg_data(reg_data), .reg_clr(reg_clr),
      .data_o(data_o), .data_oe(data_oe), .model_o(model_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // ---------------- reference model state ----------------
   typedef struct {
      logic [4:0] a;
      logic [7:0] d;
      int         s;
   } wr_t;

   wr_t        hist[$];
   int         age [2];
   int         len [2];
   logic [7:0] val [2];
   logic [1:0] m_model;
   logic       m_prev_res;
   logic       e_we;
   logic [1:0] e_sel;
   logic [4:0] e_addr;
   logic [7:0] e_data;
   logic       e_clr;
   logic [7:0] e_do;
   logic       e_oe;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      m_model    = 2'b00;
      m_prev_res = 1'b0;
      for (int i = 0; i < 2; i++) begin
         age[i] = 0;
         len[i] = L6581;
         val[i] = 8'h00;
      end
      e_we = 0; e_sel = 0; e_addr = 0; e_data = 0; e_clr = 0; e_do = 0; e_oe = 0;
   endtask

   function automatic logic [7:0] ro_of(input int s, input logic [4:0] a);
      logic [31:0] w;
      w = (s == 1) ? ro_bytes[63:32] : ro_bytes[31:0];
      case (a)
         5'h19:   return w[31:24];
         5'h1A:   return w[23:16];
         5'h1B:   return w[15:8];
         default: return w[7:0];
      endcase
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".reg_we"},   32'(reg_we),   32'(e_we));
      chk({tag, ".reg_sel"},  32'(reg_sel),  32'(e_sel));
      chk({tag, ".reg_addr"}, 32'(reg_addr), 32'(e_addr));
      chk({tag, ".reg_data"}, 32'(reg_data), 32'(e_data));
      chk({tag, ".reg_clr"},  32'(reg_clr),  32'(e_clr));
      chk({tag, ".data_o"},   32'(data_o),   32'(e_do));
      chk({tag, ".data_oe"},  32'(data_oe),  32'(e_oe));
      chk({tag, ".model_o"},  32'(model_o),  32'(m_model));
   endtask

   // One clock cycle: drive inputs, predict, clock, compare.
   task automatic step(input string tag, input logic bv_i, input logic [1:0] cs_i,
                       input logic [4:0] a_i, input logic [7:0] d_i, input logic we_i,
                       input logic oe_i, input logic res_i, input logic tick_i);
      int         s;
      logic       acc, wr, rd, ro_in, magic;
      logic [7:0] vis [2];
      logic [7:0] rob;
      bus_valid = bv_i; cs = cs_i; addr = a_i; data_i = d_i;
      we = we_i; oe = oe_i; res = res_i; tick = tick_i;

      s     = cs_i[0] ? 0 : 1;
      acc   = bv_i && (cs_i != 2'b00) && !res_i;
      wr    = acc && we_i;
      rd    = acc && !we_i;
      ro_in = (a_i >= 5'h19) && (a_i <= 5'h1C);
      rob   = ro_of(s, a_i);
      for (int i = 0; i < 2; i++) vis[i] = (age[i] >= len[i]) ? 8'h00 : val[i];

      e_we = wr;
      if (wr) begin
         e_sel  = (s == 1) ? 2'b10 : 2'b01;
         e_addr = a_i;
         e_data = d_i;
      end
      e_clr      = res_i && !m_prev_res;
      m_prev_res = res_i;
      if (rd) e_do = ro_in ? rob : vis[s];
      if (res_i)                          e_oe = 1'b0;
      else if (rd)                        e_oe = 1'b1;
      else if (bv_i && cs_i == 2'b00)     e_oe = 1'b0;
      else if (!oe_i)                     e_oe = 1'b0;

      // Unlock = the four previous writes were the magic bytes to 'h1F of this chip.
      if (res_i) begin
         hist.delete();
      end else if (wr) begin
         magic = (hist.size() == 4);
         if (magic) begin
            magic = (hist[0].a == 5'h1F && hist[0].d == 8'h52 && hist[0].s == s) &&
                    (hist[1].a == 5'h1F && hist[1].d == 8'h44 && hist[1].s == s) &&
                    (hist[2].a == 5'h1F && hist[2].d == 8'h49 && hist[2].s == s) &&
                    (hist[3].a == 5'h1F && hist[3].d == 8'h50 && hist[3].s == s);
         end
         if (magic && a_i == 5'h1E) m_model[s] = d_i[0];
         hist.push_back('{a_i, d_i, s});
         if (hist.size() > 4) void'(hist.pop_front());
      end

      for (int i = 0; i < 2; i++) begin
         if (res_i) begin
            val[i] = 8'h00; age[i] = 0; len[i] = m_model[i] ? L8580 : L6581;
         end else if ((wr || (rd && ro_in)) && s == i) begin
            val[i] = wr ? d_i : rob; age[i] = 0; len[i] = m_model[i] ? L8580 : L6581;
         end else if (tick_i) begin
            if (age[i] < L8580 + 1) age[i]++;
         end
      end

      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic wr_op(input string tag, input logic [1:0] c, input logic [4:0] a, input logic [7:0] d);
      step(tag, 1'b1, c, a, d, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic rd_op(input string tag, input logic [1:0] c, input logic [4:0] a);
      step(tag, 1'b1, c, a, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic idle(input string tag, input int n, input logic t);
      for (int k = 0; k < n; k++) step(tag, 1'b0, 2'b00, 5'h00, 8'h00, 1'b0, 1'b1, 1'b0, t);
   endtask

   initial begin
      rst_n = 1'b0; tick = 0; bus_valid = 0; cs = 0; addr = 0; data_i = 0;
      we = 0; oe = 0; res = 0; ro_bytes = 64'h0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: write to SID1 forwarded one cycle later, single-cycle strobe
      wr_op("t1_wr", 2'b10, 5'h04, 8'h41);
      chk("t1_we", 32'(reg_we), 32'd1);
      chk("t1_sel", 32'(reg_sel), 32'h2);
      chk("t1_addr", 32'(reg_addr), 32'h04);
      chk("t1_data", 32'(reg_data), 32'h41);
      idle("t1_idle", 1, 1'b0);
      chk("t1_we_off", 32'(reg_we), 32'd0);
      chk("t1_hold", 32'(reg_data), 32'h41);

      // 2: open-bus read returns last written byte; data_oe until oe low
      wr_op("t2_wr", 2'b01, 5'h00, 8'hA5);
      rd_op("t2_rd", 2'b01, 5'h05);
      chk("t2_data", 32'(data_o), 32'hA5);
      chk("t2_oe", 32'(data_oe), 32'd1);
      idle("t2_hold", 2, 1'b0);
      chk("t2_oe_hold", 32'(data_oe), 32'd1);
      step("t2_oe0", 1'b0, 2'b00, 5'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2_oe_off", 32'(data_oe), 32'd0);

      // 3: 6581 decay boundary; tick coinciding with the write must not count
      wr_op("t3_wr", 2'b01, 5'h00, 8'hA5);
      idle("t3_decay", L6581, 1'b1);
      rd_op("t3_rd", 2'b01, 5'h05);
      chk("t3_decayed", 32'(data_o), 32'h00);
      step("t3_wr2", 1'b1, 2'b01, 5'h00, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
      idle("t3_decay2", L6581 - 1, 1'b1);
      rd_op("t3_rd2", 2'b01, 5'h05);
      chk("t3_alive", 32'(data_o), 32'hA5);

      // 4: read-only register read loads the latch
      ro_bytes = {32'h1122337F, 32'hA1B2C3D4};
      rd_op("t4_env3", 2'b10, 5'h1C);
      chk("t4_env3", 32'(data_o), 32'h7F);
      rd_op("t4_open", 2'b10, 5'h10);
      chk("t4_open", 32'(data_o), 32'h7F);
      rd_op("t4_potx0", 2'b01, 5'h19);
      chk("t4_potx0", 32'(data_o), 32'hA1);

      // 5: unlock SID1 into 8580; an interleaved foreign write breaks the sequence
      wr_op("t5_m0", 2'b10, 5'h1F, 8'h52);
      wr_op("t5_m1", 2'b10, 5'h1F, 8'h44);
      wr_op("t5_m2", 2'b10, 5'h1F, 8'h49);
      wr_op("t5_m3", 2'b10, 5'h1F, 8'h50);
      wr_op("t5_set", 2'b10, 5'h1E, 8'h01);
      chk("t5_model", 32'(model_o), 32'h2);
      wr_op("t5b_m0", 2'b10, 5'h1F, 8'h52);
      wr_op("t5b_m1", 2'b10, 5'h1F, 8'h44);
      wr_op("t5b_x",  2'b01, 5'h1F, 8'h00);
      wr_op("t5b_m2", 2'b10, 5'h1F, 8'h49);
      wr_op("t5b_m3", 2'b10, 5'h1F, 8'h50);
      wr_op("t5b_set", 2'b10, 5'h1E, 8'h00);
      chk("t5b_model", 32'(model_o), 32'h2);
      wr_op("t5c_wr", 2'b10, 5'h00, 8'h5A);
      idle("t5c_decay", L6581, 1'b1);
      rd_op("t5c_rd", 2'b10, 5'h05);
      chk("t5c_8580", 32'(data_o), 32'h5A);

      // 6: lowest cs wins; RES behaviour
      wr_op("t6_both", 2'b11, 5'h02, 8'h33);
      chk("t6_sel", 32'(reg_sel), 32'h1);
      step("t6_res1", 1'b1, 2'b01, 5'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t6_clr", 32'(reg_clr), 32'd1);
      chk("t6_nowe", 32'(reg_we), 32'd0);
      step("t6_res2", 1'b1, 2'b10, 5'h1C, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
      step("t6_res3", 1'b0, 2'b00, 5'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("t6_clr_off", 32'(reg_clr), 32'd0);
      idle("t6_post", 1, 1'b0);
      rd_op("t6_rd", 2'b10, 5'h05);
      chk("t6_latch0", 32'(data_o), 32'h00);
      chk("t6_model", 32'(model_o), 32'h2);

      // Randomised traffic against the model
      for (int k = 0; k < 600; k++) begin
         logic [4:0] a;
         logic [7:0] d;
         case ($urandom_range(0, 3))
            0:       a = 5'h1F;
            1:       a = 5'h1E;
            2:       a = 5'($urandom_range(5'h19, 5'h1C));
            default: a = 5'($urandom_range(0, 31));
         endcase
         case ($urandom_range(0, 5))
            0:       d = 8'h52;
            1:       d = 8'h44;
            2:       d = 8'h49;
            3:       d = 8'h50;
            default: d = 8'($urandom_range(0, 255));
         endcase
         if ($urandom_range(0, 15) == 0) ro_bytes = {$urandom(), $urandom()};
         step("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), a, d,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
              1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset mid-operation kills a pending write strobe
      wr_op("ar_wr", 2'b01, 5'h03, 8'h99);
      #2;
      bus_valid = 0; cs = 0; we = 0; res = 0; tick = 0; oe = 0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("arst");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      idle("ar_post", 2, 1'b0);
      rd_op("ar_rd", 2'b10, 5'h05);
      chk("ar_latch0", 32'(data_o), 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
